// File: rtl/stack_unit.sv
// stack_unit: parametrised push/pop stack with flags, flush and busy handshake.
// Define STACK_PEEK_EN to add the combinational top_out peek port.
module stack_unit #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int SP_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clear,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_req,
    output logic [DATA_W-1:0] pop_out,
    output logic              push_done,
    output logic              pop_done,
    output logic              busy,
    output logic [SP_W-1:0]   sp_out,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
`ifdef STACK_PEEK_EN
    ,output logic [DATA_W-1:0] top_out
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PUSH, POP, DONE} state_t;

    state_t            state, state_nxt;
    logic [SP_W-1:0]   sp;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx, rd_idx;

    assign wr_idx = sp[AW-1:0];
    assign rd_idx = AW'(sp - SP_W'(1));
    assign sp_out = sp;
    assign empty  = sp == '0;
    assign full   = sp == SP_W'(DEPTH);
    assign busy   = state != IDLE;

`ifdef STACK_PEEK_EN
    assign top_out = empty ? '0 : mem[rd_idx];
`endif

    always_comb begin
        state_nxt = clear ? IDLE :
                    state == IDLE ? (push_req ? PUSH : pop_req ? POP : IDLE) :
                    state == DONE ? IDLE : DONE;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // RAM is not reset; a write only lands when the push really completes
    always_ff @(posedge clk) begin
        if (rst_b && !clear && state == PUSH && !full)
            mem[wr_idx] <= data_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sp        <= '0;
            data_q    <= '0;
            pop_out   <= '0;
            push_done <= 1'b0;
            pop_done  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            sp        <= '0;
            push_done <= 1'b0;
            pop_done  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            push_done <= 1'b0;
            pop_done  <= 1'b0;
            if (state == IDLE && push_req)
                data_q <= push_data;
            if (state == PUSH) begin
                push_done <= 1'b1;
                if (full)
                    overflow <= 1'b1;
                else
                    sp <= sp + SP_W'(1);
            end
            if (state == POP) begin
                pop_done <= 1'b1;
                if (empty) begin
                    underflow <= 1'b1;
                    pop_out   <= '0;
                end else begin
                    pop_out <= mem[rd_idx];
                    sp      <= sp - SP_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: table-driven checks of stack_unit with a pop-data scoreboard.
module tb_stack_unit;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        clear = 1'b0;
    logic        push_req = 1'b0;
    logic        pop_req = 1'b0;
    logic [15:0] push_data = '0;
    logic [15:0] pop_out;
    logic        push_done, pop_done, busy, empty, full, overflow, underflow;
    logic [4:0]  sp_out;
`ifdef STACK_PEEK_EN
    logic [15:0] top_out;
`endif

    stack_unit #(.DATA_W(16), .DEPTH(16)) dut (
        .clk(clk), .rst_b(rst_b), .clear(clear),
        .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
        .pop_out(pop_out), .push_done(push_done), .pop_done(pop_done),
        .busy(busy), .sp_out(sp_out), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
`ifdef STACK_PEEK_EN
        , .top_out(top_out)
`endif
    );

    always #5 clk = ~clk;

    // op: 0 push, 1 pop, 2 push+pop together, 3 clear pulse
    typedef struct {
        int          op;
        logic [15:0] d;
        logic [15:0] exp_pop;
        int          exp_sp;
        bit          exp_ovf;
        bit          exp_unf;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    int          checks = 0;
    int          failures = 0;
    int          row = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
        end
    endtask

    function automatic void add(input int op, input logic [15:0] d, input logic [15:0] p,
                                input int s, input bit o, input bit u);
        vec_t v;
        v.op = op; v.d = d; v.exp_pop = p; v.exp_sp = s; v.exp_ovf = o; v.exp_unf = u;
        vecs.push_back(v);
    endfunction

    task automatic run(input vec_t v);
        int n;
        if (v.op == 3) begin
            clear = 1'b1;
            @(posedge clk);
            #1 clear = 1'b0;
            @(negedge clk);
        end else begin
            push_req  = v.op != 1;
            pop_req   = v.op != 0;
            push_data = v.d;
            if (v.op == 1) sb.push_back(v.exp_pop);
            @(posedge clk);
            #1 push_req = 1'b0;
            pop_req = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!push_done && !pop_done && n < 5);
            chk("done_latency", n, 2);
            chk("push_done", {31'b0, push_done}, {31'b0, v.op != 1});
            chk("pop_done", {31'b0, pop_done}, {31'b0, v.op == 1});
            chk("busy_in_done", {31'b0, busy}, 1);
            if (pop_done) begin
                if (sb.size() == 0) chk("sb_unexpected_pop", 1, 0);
                else chk("pop_out", {16'b0, pop_out}, {16'b0, sb.pop_front()});
            end
            @(negedge clk);
            chk("done_width", {31'b0, push_done | pop_done}, 0);
            chk("busy_idle", {31'b0, busy}, 0);
        end
        chk("sp_out", {27'b0, sp_out}, v.exp_sp);
        chk("full", {31'b0, full}, {31'b0, v.exp_sp == 16});
        chk("empty", {31'b0, empty}, {31'b0, v.exp_sp == 0});
        chk("overflow", {31'b0, overflow}, {31'b0, v.exp_ovf});
        chk("underflow", {31'b0, underflow}, {31'b0, v.exp_unf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        add(0, 16'h1234, 0, 1, 0, 0);
        add(0, 16'hABCD, 0, 2, 0, 0);
        add(1, 0, 16'hABCD, 1, 0, 0);
        add(1, 0, 16'h1234, 0, 0, 0);
        add(1, 0, 16'h0000, 0, 0, 1);
        add(3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 16'(i), 0, i + 1, 0, 0);
        add(0, 16'hDEAD, 0, 16, 1, 0);
        add(1, 0, 16'h000F, 15, 1, 0);
        add(3, 0, 0, 0, 0, 0);
        add(0, 16'h00A0, 0, 1, 0, 0);
        add(0, 16'h00B0, 0, 2, 0, 0);
        add(0, 16'h00C0, 0, 3, 0, 0);
        add(2, 16'h00D0, 0, 4, 0, 0);
        add(1, 0, 16'h00D0, 3, 0, 0);
        add(1, 0, 16'h00C0, 2, 0, 0);
        add(0, 16'h55AA, 0, 3, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst_sp", {27'b0, sp_out}, 0);
        chk("rst_empty", {31'b0, empty}, 1);
        chk("rst_full", {31'b0, full}, 0);
        chk("rst_pop_out", {16'b0, pop_out}, 0);
        chk("rst_dones", {30'b0, push_done, pop_done}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_flags", {30'b0, overflow, underflow}, 0);
        rst_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            run(vecs[i]);
        end
        row = -1;
`ifdef STACK_PEEK_EN
        chk("peek_top", {16'b0, top_out}, 32'h55AA);
`endif

        // reset asserted while the push is in flight
        push_req = 1'b1;
        push_data = 16'hBEEF;
        @(posedge clk);
        #1 rst_b = 1'b0;
        push_req = 1'b0;
        #1;
        chk("midrst_sp", {27'b0, sp_out}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_empty", {31'b0, empty}, 1);
`ifdef STACK_PEEK_EN
        chk("midrst_top", {16'b0, top_out}, 0);
`endif
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {30'b0, push_done, pop_done}, 0);
        end
        chk("midrst_sp_after", {27'b0, sp_out}, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
